// File: rtl/fixed_dot_pkg.sv
// ----------------------------------------------------------------------------
// fixed_dot_pkg
// Shared helpers for the fixed-point dot-product datapath.
//   acc_width() : accumulator width that holds PARALLELISM*IN_DEPTH
//                 full-precision products without overflow.
//   narrow()    : arithmetic right shift (rounds toward -inf), then reduction
//                 to the output width.
// Build option: FIXED_DOT_ACC_SATURATE_EN
//   defined   -> narrow() clamps to the signed output range
//   undefined -> narrow() keeps the low output bits (two's-complement wrap)
// ----------------------------------------------------------------------------
package fixed_dot_pkg;

    // Working width for narrow(); callers sign-extend into it and cast the
    // result down to their output width.
    localparam int NARROW_W = 128;

    function automatic int acc_width(
        input int dw,
        input int ww,
        input int par,
        input int depth
    );
        return dw + ww + $clog2(par) + $clog2(depth) + 1;
    endfunction

    // Returns the narrowed value sign-extended to NARROW_W bits.
    function automatic logic signed [NARROW_W-1:0] narrow(
        input logic signed [NARROW_W-1:0] value,
        input int                         shift,
        input int                         ow
    );
        logic signed [NARROW_W-1:0] shifted;
        logic signed [NARROW_W-1:0] result;
`ifdef FIXED_DOT_ACC_SATURATE_EN
        logic signed [NARROW_W-1:0] max_v;
        logic signed [NARROW_W-1:0] min_v;
`endif
        shifted = value >>> shift;
`ifdef FIXED_DOT_ACC_SATURATE_EN
        max_v = (128'sd1 <<< (ow - 1)) - 128'sd1;
        min_v = -(128'sd1 <<< (ow - 1));
        if (shifted > max_v) begin
            result = max_v;
        end else if (shifted < min_v) begin
            result = min_v;
        end else begin
            result = shifted;
        end
`else
        // Keep the low ow bits and re-sign-extend from bit ow-1.
        result = (shifted <<< (NARROW_W - ow)) >>> (NARROW_W - ow);
`endif
        return result;
    endfunction

endpackage

// File: rtl/fixed_dot_product.sv
// ----------------------------------------------------------------------------
// fixed_dot_product
// Purely combinational signed dot product of one beat: PAR full-precision
// multipliers followed by a binary adder tree.
// Ports:
//   data_in [PAR] : IN_W-bit signed lanes
//   weight  [PAR] : WT_W-bit signed lanes
//   sum           : SUM_W-bit signed sum of the lane products
//                   (SUM_W must exceed IN_W+WT_W)
// ----------------------------------------------------------------------------
module fixed_dot_product
    import fixed_dot_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int WT_W  = 16,
    parameter int PAR   = 4,
    parameter int SUM_W = 35
) (
    input  logic [IN_W-1:0]         data_in [PAR],
    input  logic [WT_W-1:0]         weight  [PAR],
    output logic signed [SUM_W-1:0] sum
);

    localparam int PROD_W = IN_W + WT_W;
    localparam int LEVELS = (PAR > 1) ? $clog2(PAR) : 0;
    localparam int LEAVES = 1 << LEVELS;

    // Lane multiplies feed the leaves (unused leaves are zero); node k sums
    // children 2k and 2k+1, so node 1 is the root.
    always_comb begin
        logic signed [PROD_W-1:0] a_ext;
        logic signed [PROD_W-1:0] w_ext;
        logic signed [PROD_W-1:0] prod;
        logic signed [SUM_W-1:0]  node [2*LEAVES];
        a_ext = {PROD_W{1'b0}};
        w_ext = {PROD_W{1'b0}};
        prod  = {PROD_W{1'b0}};
        for (int n = 0; n < 2 * LEAVES; n++) begin
            node[n] = {SUM_W{1'b0}};
        end
        for (int i = 0; i < LEAVES; i++) begin
            if (i < PAR) begin
                a_ext = {{WT_W{data_in[i][IN_W-1]}}, data_in[i]};
                w_ext = {{IN_W{weight[i][WT_W-1]}}, weight[i]};
                prod  = a_ext * w_ext;
                node[LEAVES + i] = {{(SUM_W - PROD_W){prod[PROD_W-1]}}, prod};
            end else begin
                node[LEAVES + i] = {SUM_W{1'b0}};
            end
        end
        for (int k = LEAVES - 1; k >= 1; k--) begin
            node[k] = node[2 * k] + node[2 * k + 1];
        end
        sum = node[1];
    end

endmodule

// File: rtl/fixed_dot_accumulate.sv
// ----------------------------------------------------------------------------
// fixed_dot_accumulate
// Streaming dot-product accumulator: joins an activation stream with a weight
// stream, sums PARALLELISM products per beat over IN_DEPTH beats, and emits
// one rescaled element per IN_DEPTH beats.
// Ports:
//   clk, rst (async, active-low)
//   data_in[PARALLELISM], data_in_valid, data_in_ready : activation beat
//   weight[PARALLELISM],  weight_valid,  weight_ready  : weight beat
//   data_out, data_out_valid, data_out_ready           : registered result
// Build option: FIXED_DOT_ACC_SATURATE_EN selects saturating narrowing
// (default build wraps). Latency is the same in both builds.
// ----------------------------------------------------------------------------
module fixed_dot_accumulate
    import fixed_dot_pkg::*;
#(
    parameter int DATA_IN_PRECISION_0  = 16,
    parameter int DATA_IN_PRECISION_1  = 3,
    parameter int WEIGHT_PRECISION_0   = 16,
    parameter int WEIGHT_PRECISION_1   = 3,
    parameter int DATA_OUT_PRECISION_0 = 16,
    parameter int DATA_OUT_PRECISION_1 = 3,
    parameter int PARALLELISM          = 4,
    parameter int IN_DEPTH             = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_IN_PRECISION_0-1:0]  data_in [PARALLELISM],
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    input  logic [WEIGHT_PRECISION_0-1:0]   weight  [PARALLELISM],
    input  logic                            weight_valid,
    output logic                            weight_ready,
    output logic [DATA_OUT_PRECISION_0-1:0] data_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready
);

    localparam int ACC_W = acc_width(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0,
                                     PARALLELISM, IN_DEPTH);
    localparam int SHIFT = DATA_IN_PRECISION_1 + WEIGHT_PRECISION_1
                           - DATA_OUT_PRECISION_1;
    localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_DEPTH - 1);

    logic                            can_accept_s;
    logic                            fire_s;
    logic                            final_fire_s;
    logic signed [ACC_W-1:0]         beat_sum_s;
    logic signed [ACC_W-1:0]         acc_total_s;
    logic [DATA_OUT_PRECISION_0-1:0] narrowed_s;
    logic signed [ACC_W-1:0]         acc_r;
    logic [CNT_W-1:0]                cnt_r;

    // Join: both streams advance together, and only when the output register
    // is free or being emptied this cycle.
    always_comb begin
        can_accept_s  = !data_out_valid || data_out_ready;
        data_in_ready = weight_valid && can_accept_s;
        weight_ready  = data_in_valid && can_accept_s;
        fire_s        = data_in_valid && weight_valid && can_accept_s;
        final_fire_s  = fire_s && (cnt_r == LAST_CNT);
    end

    fixed_dot_product #(
        .IN_W  (DATA_IN_PRECISION_0),
        .WT_W  (WEIGHT_PRECISION_0),
        .PAR   (PARALLELISM),
        .SUM_W (ACC_W)
    ) u_dot (
        .data_in (data_in),
        .weight  (weight),
        .sum     (beat_sum_s)
    );

    // Running total including the current beat, and its rescaled form that
    // the output register captures on the final beat.
    always_comb begin
        acc_total_s = acc_r + beat_sum_s;
        narrowed_s  = DATA_OUT_PRECISION_0'(narrow(
                          {{(NARROW_W - ACC_W){acc_total_s[ACC_W-1]}}, acc_total_s},
                          SHIFT, DATA_OUT_PRECISION_0));
    end

    // Accumulator, beat counter and output register; everything holds unless
    // a fire occurs, and the output valid drops once taken without a refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r          <= {ACC_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            data_out       <= {DATA_OUT_PRECISION_0{1'b0}};
            data_out_valid <= 1'b0;
        end else begin
            if (final_fire_s) begin
                acc_r    <= {ACC_W{1'b0}};
                cnt_r    <= {CNT_W{1'b0}};
                data_out <= narrowed_s;
            end else if (fire_s) begin
                acc_r <= acc_total_s;
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end

            if (final_fire_s) begin
                data_out_valid <= 1'b1;
            end else if (data_out_ready) begin
                data_out_valid <= 1'b0;
            end else begin
                data_out_valid <= data_out_valid;
            end
        end
    end

endmodule

// File: tb/tb_fixed_dot_accumulate.sv
// ----------------------------------------------------------------------------
// tb_fixed_dot_accumulate
// Self-checking bench for fixed_dot_accumulate at 8-bit data/weight/output,
// 4 fractional bits, PARALLELISM=4, IN_DEPTH=2. Expected overflow results
// follow FIXED_DOT_ACC_SATURATE_EN when it is defined for the build.
// ----------------------------------------------------------------------------
module tb_fixed_dot_accumulate;

    localparam int P    = 4;
    localparam int D    = 2;
    localparam int FRAC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in [P];
    logic       data_in_valid;
    logic       data_in_ready;
    logic [7:0] weight [P];
    logic       weight_valid;
    logic       weight_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fixed_dot_accumulate #(
        .DATA_IN_PRECISION_0  (8),
        .DATA_IN_PRECISION_1  (4),
        .WEIGHT_PRECISION_0   (8),
        .WEIGHT_PRECISION_1   (4),
        .DATA_OUT_PRECISION_0 (8),
        .DATA_OUT_PRECISION_1 (4),
        .PARALLELISM          (P),
        .IN_DEPTH             (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .weight         (weight),
        .weight_valid   (weight_valid),
        .weight_ready   (weight_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    typedef struct {
        string      name;
        logic [7:0] a0;
        logic [7:0] w0;
        logic [7:0] a1;
        logic [7:0] w1;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Reference rescale: floor-shift the exact sum, then clamp or wrap to 8 bits.
    function automatic logic [7:0] ref_narrow(input int total);
        int s;
        s = total >>> FRAC;
`ifdef FIXED_DOT_ACC_SATURATE_EN
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    task automatic drive_lanes(input logic [7:0] a, input logic [7:0] w);
        for (int i = 0; i < P; i++) begin
            data_in[i] = a;
            weight[i]  = w;
        end
    endtask

    // One beat with both valids high for exactly one rising edge.
    task automatic send_beat(input logic [7:0] a, input logic [7:0] w);
        @(negedge clk);
        drive_lanes(a, w);
        data_in_valid = 1'b1;
        weight_valid  = 1'b1;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        weight_valid  = 1'b0;
    endtask

    initial begin
        logic [7:0] cur_a [P];
        logic [7:0] cur_w [P];
        int         beats_q [$];
        logic       m_valid;
        logic [7:0] m_out;
        logic       dv, wv, dor, can, fire;
        int         bs, total;

        rst            = 1'b0;
        data_in_valid  = 1'b0;
        weight_valid   = 1'b0;
        data_out_ready = 1'b1;
        drive_lanes(8'h00, 8'h00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check8("reset_data_out", data_out, 8'h00);
        check1("reset_valid", data_out_valid, 1'b0);
        check1("reset_data_in_ready", data_in_ready, 1'b0);
        check1("reset_weight_ready", weight_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table: uniform lanes, two beats per output
        vecs[0] = '{"basic",     8'h08, 8'h10, 8'h08, 8'h10, 8'h40};
        vecs[1] = '{"negative",  8'hF0, 8'h08, 8'hF0, 8'h08, 8'hC0};
        vecs[2] = '{"trunc_pos", 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        vecs[3] = '{"trunc_neg", 8'hFF, 8'h01, 8'hFF, 8'h01, 8'hFF};
        vecs[4] = '{"mixed",     8'h08, 8'h10, 8'hF0, 8'h08, 8'h00};
`ifdef FIXED_DOT_ACC_SATURATE_EN
        vecs[5] = '{"overflow",  8'h10, 8'h10, 8'h10, 8'h10, 8'h7F};
`else
        vecs[5] = '{"overflow",  8'h10, 8'h10, 8'h10, 8'h10, 8'h80};
`endif
        for (int v = 0; v < 6; v++) begin
            send_beat(vecs[v].a0, vecs[v].w0);
            check1({vecs[v].name, "_valid_after_beat0"}, data_out_valid, 1'b0);
            send_beat(vecs[v].a1, vecs[v].w1);
            check1({vecs[v].name, "_valid_after_beat1"}, data_out_valid, 1'b1);
            check8({vecs[v].name, "_data_out"}, data_out, vecs[v].exp);
        end

        // Join and backpressure: stall with a result held, then release
        send_beat(8'h08, 8'h10);
        send_beat(8'h08, 8'h10);
        check8("bp_first_result", data_out, 8'h40);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            data_out_ready = 1'b0;
            data_in_valid  = 1'b1;
            weight_valid   = ($urandom_range(0, 1) == 32'd1);
            drive_lanes(8'h10, 8'h10);
            #1;
            check1("bp_stall_data_in_ready", data_in_ready, 1'b0);
            check1("bp_stall_weight_ready", weight_ready, 1'b0);
            @(posedge clk);
            #1;
            check1("bp_stall_valid", data_out_valid, 1'b1);
            check8("bp_stall_data_out", data_out, 8'h40);
        end
        @(negedge clk);
        data_out_ready = 1'b1;
        data_in_valid  = 1'b1;
        weight_valid   = 1'b1;
        drive_lanes(8'hF0, 8'h08);
        #1;
        check1("bp_release_data_in_ready", data_in_ready, 1'b1);
        check1("bp_release_weight_ready", weight_ready, 1'b1);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        weight_valid  = 1'b0;
        check1("bp_release_valid_cleared", data_out_valid, 1'b0);
        send_beat(8'hF0, 8'h08);
        check1("bp_second_valid", data_out_valid, 1'b1);
        check8("bp_second_result", data_out, 8'hC0);

        // Reset mid-accumulation discards the partial sum
        send_beat(8'h10, 8'h10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check8("midrst_data_out", data_out, 8'h00);
        check1("midrst_valid", data_out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        send_beat(8'h08, 8'h10);
        check1("midrst_valid_after_beat0", data_out_valid, 1'b0);
        send_beat(8'h08, 8'h10);
        check1("midrst_valid_after_beat1", data_out_valid, 1'b1);
        check8("midrst_result", data_out, 8'h40);

        // Drain to an idle state before the random phase
        @(negedge clk);
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check1("drain_valid", data_out_valid, 1'b0);

        // Random traffic against the behavioural model
        m_valid = 1'b0;
        m_out   = 8'h00;
        for (int i = 0; i < P; i++) begin
            cur_a[i] = 8'($urandom);
            cur_w[i] = 8'($urandom);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            dv  = ($urandom_range(0, 3) != 32'd0);
            wv  = ($urandom_range(0, 3) != 32'd0);
            dor = ($urandom_range(0, 2) != 32'd0);
            data_in_valid  = dv;
            weight_valid   = wv;
            data_out_ready = dor;
            for (int i = 0; i < P; i++) begin
                data_in[i] = cur_a[i];
                weight[i]  = cur_w[i];
            end
            #1;
            can  = !m_valid || dor;
            fire = dv && wv && can;
            check1("rnd_data_in_ready", data_in_ready, wv && can);
            check1("rnd_weight_ready", weight_ready, dv && can);
            @(posedge clk);
            #1;
            if (dor) m_valid = 1'b0;
            if (fire) begin
                bs = 0;
                for (int i = 0; i < P; i++) begin
                    bs += int'($signed(cur_a[i])) * int'($signed(cur_w[i]));
                end
                beats_q.push_back(bs);
                if (beats_q.size() == D) begin
                    total = 0;
                    foreach (beats_q[k]) total += beats_q[k];
                    beats_q.delete();
                    m_out   = ref_narrow(total);
                    m_valid = 1'b1;
                end
                for (int i = 0; i < P; i++) begin
                    cur_a[i] = 8'($urandom);
                    cur_w[i] = 8'($urandom);
                end
            end
            check1("rnd_valid", data_out_valid, m_valid);
            if (m_valid) begin
                check8("rnd_data_out", data_out, m_out);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
